// File: rtl/logic_unit_pipe.sv
// Registered bitwise logic stage with valid/ready handshake,
// a chained-operand mode fed by the last accepted result, and zero/parity flags.
module logic_unit_pipe #(
    parameter int               WIDTH      = 8,
    parameter logic [WIDTH-1:0] CHAIN_INIT = '0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    input  logic [2:0]       in_op,
    input  logic             in_chain,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_z,
    output logic             out_zero,
    output logic             out_parity
);

    logic             r_valid;
    logic [WIDTH-1:0] r_z;
    logic             r_zero;
    logic             r_parity;
    logic [WIDTH-1:0] r_chain;

    logic             w_accept;
    logic [WIDTH-1:0] w_b;
    logic [WIDTH-1:0] w_z;

    assign in_ready = !r_valid || out_ready;
    assign w_accept = in_valid && in_ready;
    assign w_b      = in_chain ? r_chain : in_b;

    always_comb begin
        w_z = '0;
        unique case (in_op)
            3'd0: w_z = in_a & w_b;
            3'd1: w_z = in_a | w_b;
            3'd2: w_z = ~(in_a & w_b);
            3'd3: w_z = ~(in_a | w_b);
            3'd4: w_z = in_a ^ w_b;
            3'd5: w_z = ~(in_a ^ w_b);
            3'd6: w_z = ~in_a;
            3'd7: w_z = in_a;
            default: w_z = '0;
        endcase
    end

    // Accept takes priority over drain, so a simultaneous drain+accept keeps valid high.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_valid  <= 1'b0;
            r_z      <= '0;
            r_zero   <= 1'b0;
            r_parity <= 1'b0;
            r_chain  <= CHAIN_INIT;
        end else if (w_accept) begin
            r_valid  <= 1'b1;
            r_z      <= w_z;
            r_zero   <= (w_z == '0);
            r_parity <= ^w_z;
            r_chain  <= w_z;
        end else if (r_valid && out_ready) begin
            r_valid  <= 1'b0;
        end
    end

    assign out_valid  = r_valid;
    assign out_z      = r_z;
    assign out_zero   = r_zero;
    assign out_parity = r_parity;

endmodule

// File: tb/tb_logic_unit_pipe.sv
// Self-checking bench for logic_unit_pipe: directed cases from the behaviour
// description followed by randomized traffic against a transaction-level model.
module tb_logic_unit_pipe;

    localparam int W = 8;

    logic         clk = 1'b0;
    logic         rst;
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] in_a;
    logic [W-1:0] in_b;
    logic [2:0]   in_op;
    logic         in_chain;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] out_z;
    logic         out_zero;
    logic         out_parity;

    int total = 0;
    int bad   = 0;

    // Reference model state: the one held result plus the chain value.
    bit           m_valid = 1'b0;
    logic [W-1:0] m_z     = '0;
    bit           m_zero  = 1'b0;
    bit           m_par   = 1'b0;
    logic [W-1:0] m_chain = '0;

    logic [W-1:0] all_exp [8] = '{8'h05, 8'hAF, 8'hFA, 8'h50,
                                  8'hAA, 8'h55, 8'h5A, 8'hA5};

    logic_unit_pipe #(.WIDTH(W), .CHAIN_INIT(8'h00)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_a      (in_a),
        .in_b      (in_b),
        .in_op     (in_op),
        .in_chain  (in_chain),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_z     (out_z),
        .out_zero  (out_zero),
        .out_parity(out_parity)
    );

    always #5 clk = ~clk;

    function automatic logic [W-1:0] ref_op(input logic [2:0] op,
                                            input logic [W-1:0] a,
                                            input logic [W-1:0] b);
        logic [W-1:0] r;
        r = '0;
        for (int i = 0; i < W; i++) begin
            case (op)
                3'd0: r[i] = a[i] && b[i];
                3'd1: r[i] = a[i] || b[i];
                3'd2: r[i] = !(a[i] && b[i]);
                3'd3: r[i] = !(a[i] || b[i]);
                3'd4: r[i] = a[i] != b[i];
                3'd5: r[i] = a[i] == b[i];
                3'd6: r[i] = !a[i];
                default: r[i] = a[i];
            endcase
        end
        return r;
    endfunction

    function automatic bit ones_odd(input logic [W-1:0] v);
        int n;
        n = 0;
        for (int i = 0; i < W; i++) n += int'(v[i]);
        return (n % 2) == 1;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One clock: drive at negedge, check in_ready, update model at posedge,
    // then check the registered outputs 1 time unit after the edge.
    task automatic cyc(input bit r, input bit v, input logic [W-1:0] a,
                       input logic [W-1:0] b, input logic [2:0] op,
                       input bit ch, input bit ordy);
        bit           acc;
        logic [W-1:0] z;
        rst = r; in_valid = v; in_a = a; in_b = b;
        in_op = op; in_chain = ch; out_ready = ordy;
        #1;
        chk("in_ready", 32'(in_ready), 32'(!m_valid || ordy));
        acc = v && (!m_valid || ordy) && !r;
        @(posedge clk);
        #1;
        if (r) begin
            m_valid = 0; m_z = '0; m_zero = 0; m_par = 0; m_chain = '0;
        end else if (acc) begin
            z = ref_op(op, a, ch ? m_chain : b);
            m_valid = 1; m_z = z; m_zero = (z == 0);
            m_par = ones_odd(z); m_chain = z;
        end else if (m_valid && ordy) begin
            m_valid = 0;
        end
        chk("out_valid", 32'(out_valid), 32'(m_valid));
        chk("out_z", 32'(out_z), 32'(m_z));
        chk("out_zero", 32'(out_zero), 32'(m_zero));
        chk("out_parity", 32'(out_parity), 32'(m_par));
        @(negedge clk);
    endtask

    initial begin
        rst = 1; in_valid = 0; in_a = '0; in_b = '0;
        in_op = '0; in_chain = 0; out_ready = 1;
        @(negedge clk);
        cyc(1, 0, 8'h00, 8'h00, 3'd0, 0, 1);
        cyc(1, 1, 8'hFF, 8'hFF, 3'd7, 0, 1);
        chk("rst_z", 32'(out_z), 32'h0);

        // Basic AND
        cyc(0, 1, 8'hF0, 8'h3C, 3'd0, 0, 1);
        chk("and_z", 32'(out_z), 32'h30);

        // All ops back-to-back
        for (int k = 0; k < 8; k++) begin
            cyc(0, 1, 8'hA5, 8'h0F, 3'(k), 0, 1);
            chk("allop_z", 32'(out_z), 32'(all_exp[k]));
            chk("allop_valid", 32'(out_valid), 32'h1);
        end
        cyc(0, 0, 8'h00, 8'h00, 3'd0, 0, 1);
        chk("drain_valid", 32'(out_valid), 32'h0);

        // Backpressure
        cyc(0, 1, 8'hFF, 8'h0F, 3'd4, 0, 1);
        for (int k = 0; k < 3; k++) begin
            cyc(0, 1, 8'h11, 8'h33, 3'd0, 0, 0);
            chk("bp_z", 32'(out_z), 32'hF0);
            chk("bp_ready", 32'(in_ready), 32'h0);
        end
        cyc(0, 1, 8'h11, 8'h33, 3'd0, 0, 1);
        chk("bp_release_z", 32'(out_z), 32'h11);

        // Chain
        cyc(0, 1, 8'h0F, 8'hFF, 3'd4, 0, 1);
        chk("chain0_z", 32'(out_z), 32'hF0);
        cyc(0, 1, 8'h3C, 8'h00, 3'd0, 1, 1);
        chk("chain1_z", 32'(out_z), 32'h30);
        cyc(0, 1, 8'h00, 8'h00, 3'd3, 1, 1);
        chk("chain2_z", 32'(out_z), 32'hCF);
        chk("chain2_par", 32'(out_parity), 32'h0);

        // Zero flag
        cyc(0, 1, 8'hFF, 8'h00, 3'd6, 0, 1);
        chk("not_zero", 32'(out_zero), 32'h1);
        cyc(0, 1, 8'h01, 8'h00, 3'd7, 0, 1);
        chk("pass_par", 32'(out_parity), 32'h1);

        // Reset mid-operation with a stalled result and chain=3C
        cyc(0, 1, 8'h3C, 8'h00, 3'd7, 0, 1);
        cyc(0, 0, 8'h00, 8'h00, 3'd0, 0, 0);
        chk("stall_valid", 32'(out_valid), 32'h1);
        cyc(1, 1, 8'hAA, 8'h55, 3'd1, 0, 0);
        chk("rst_mid_valid", 32'(out_valid), 32'h0);
        cyc(0, 1, 8'h00, 8'hFF, 3'd1, 1, 1);
        chk("rst_chain_z", 32'(out_z), 32'h00);
        chk("rst_chain_zero", 32'(out_zero), 32'h1);

        // Randomized traffic
        for (int n = 0; n < 400; n++) begin
            cyc($urandom_range(0, 39) == 0, 1'($urandom), 8'($urandom),
                8'($urandom), 3'($urandom), 1'($urandom),
                $urandom_range(0, 3) != 0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
